// File: rtl/coin_input_ctrl_pkg.sv
// Shared definitions for the coin/joystick input controller: button word bit
// map, game-core byte layouts and the coin pulser state encoding.
package coin_input_ctrl_pkg;

   localparam int BTN_W = 12;
   localparam int Q_W   = 3;

   // Debounced button word (active-low)
   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_RIGHT = 3;
   localparam int B_FIRE1 = 4;
   localparam int B_START = 8;
   localparam int B_COIN  = 9;
   localparam int B_SVC   = 11;

   // IN_P1 / IN_P2 layout (active-high)
   localparam int O_RIGHT = 0;
   localparam int O_LEFT  = 1;
   localparam int O_UP    = 2;
   localparam int O_DOWN  = 3;
   localparam int O_JUMP  = 4;

   // IN_SYS layout (active-high)
   localparam int S_SERVICE = 0;
   localparam int S_TEST    = 1;
   localparam int S_START1  = 2;
   localparam int S_START2  = 3;
   localparam int S_COIN    = 7;

   typedef enum logic [1:0] {
      COIN_IDLE = 2'd0,
      COIN_ON   = 2'd1,
      COIN_OFF  = 2'd2
   } coin_state_t;

endpackage

// File: rtl/coin_input_ctrl_coin_pulser.sv
// One coin channel: falling-edge press detect, saturating press queue and an
// ON/OFF pulse FSM timed in timebase ticks.
module coin_pulser
   import coin_input_ctrl_pkg::*;
#(
   parameter int COIN_ON_T  = 50,
   parameter int COIN_OFF_T = 50,
   parameter int COIN_Q_MAX = 7
) (
   input  logic           CLK_12M,
   input  logic           RESET,
   input  logic           tick,
   input  logic           btn_n,
   output logic           pulse,
   output logic [Q_W-1:0] q
);

   localparam int T_MAX = (COIN_ON_T > COIN_OFF_T) ? COIN_ON_T : COIN_OFF_T;
   localparam int CW    = $clog2(T_MAX + 1);

   coin_state_t    state_q, state_d;
   logic [CW-1:0]  tcnt_q, tcnt_d;
   logic [Q_W-1:0] q_q, q_d;
   logic           prev_q;
   logic           press;
   logic           deq;

   assign press = prev_q & ~btn_n;

   always_ff @(posedge CLK_12M) begin
      if (RESET) begin
         state_q <= COIN_IDLE;
         tcnt_q  <= '0;
         q_q     <= '0;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         q_q     <= q_d;
         prev_q  <= btn_n;
      end
   end

   // The counter is cleared on each state entry; the partial tick period at
   // entry counts as the first one.
   always_comb begin
      state_d = state_q;
      tcnt_d  = tick ? tcnt_q + CW'(1) : tcnt_q;
      deq     = 1'b0;
      case (state_q)
         COIN_IDLE: begin
            tcnt_d = '0;
            if (q_q != '0) begin
               state_d = COIN_ON;
               deq     = 1'b1;
            end
         end
         COIN_ON: begin
            if (tick && tcnt_q == CW'(COIN_ON_T - 1)) begin
               state_d = COIN_OFF;
               tcnt_d  = '0;
            end
         end
         COIN_OFF: begin
            if (tick && tcnt_q == CW'(COIN_OFF_T - 1)) begin
               tcnt_d = '0;
               if (q_q != '0) begin
                  state_d = COIN_ON;
                  deq     = 1'b1;
               end else begin
                  state_d = COIN_IDLE;
               end
            end
         end
         default: begin
            state_d = COIN_IDLE;
            tcnt_d  = '0;
         end
      endcase
   end

   // Simultaneous press and dequeue cancel out, even at saturation.
   always_comb begin
      q_d = q_q;
      case ({press, deq})
         2'b10:   if (q_q != Q_W'(COIN_Q_MAX)) q_d = q_q + Q_W'(1);
         2'b01:   q_d = q_q - Q_W'(1);
         default: q_d = q_q;
      endcase
   end

   assign pulse = (state_q == COIN_ON);
   assign q     = q_q;

endmodule

// File: rtl/coin_input_ctrl.sv
// Converts debounced active-low button words into active-high game-core
// input bytes, with direction cleanup and queued coin-mech pulses.
module coin_input_ctrl
   import coin_input_ctrl_pkg::*;
#(
   parameter int CLK_HZ     = 12_000_000,
   parameter int TICK_HZ    = 1000,
   parameter int COIN_ON_T  = 50,
   parameter int COIN_OFF_T = 50,
   parameter int COIN_Q_MAX = 7
) (
   input  logic             CLK_12M,
   input  logic             RESET,
   input  logic [BTN_W-1:0] BTN_P1,
   input  logic [BTN_W-1:0] BTN_P2,
   output logic [7:0]       IN_P1,
   output logic [7:0]       IN_P2,
   output logic [7:0]       IN_SYS,
   output logic [5:0]       COIN_PEND
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [1:0][BTN_W-1:0] btn_q;
   logic [1:0][7:0]       ply_d, ply_q;
   logic [7:0]            sys_d, sys_q;
   logic [PW-1:0]         presc_q;
   logic                  tick_q;
   logic [1:0]            coin;
   logic [1:0][Q_W-1:0]   qn;
   logic                  unused_btn;

   always_ff @(posedge CLK_12M) begin
      if (RESET) begin
         btn_q   <= '1;
         ply_q   <= '0;
         sys_q   <= '0;
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         btn_q   <= {BTN_P2, BTN_P1};
         ply_q   <= ply_d;
         sys_q   <= sys_d;
         presc_q <= (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
         tick_q  <= (presc_q == PW'(DIV - 1));
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_player
         logic       up_p, dn_p, lf_p, rt_p;
         logic [7:0] byte_d;

         assign up_p = ~btn_q[gi][B_UP];
         assign dn_p = ~btn_q[gi][B_DOWN];
         assign lf_p = ~btn_q[gi][B_LEFT];
         assign rt_p = ~btn_q[gi][B_RIGHT];

         // Opposing directions pressed together cancel each other.
         always_comb begin
            byte_d          = '0;
            byte_d[O_UP]    = up_p & ~dn_p;
            byte_d[O_DOWN]  = dn_p & ~up_p;
            byte_d[O_LEFT]  = lf_p & ~rt_p;
            byte_d[O_RIGHT] = rt_p & ~lf_p;
            byte_d[O_JUMP]  = ~btn_q[gi][B_FIRE1];
         end

         assign ply_d[gi] = byte_d;

         coin_pulser #(
            .COIN_ON_T  (COIN_ON_T),
            .COIN_OFF_T (COIN_OFF_T),
            .COIN_Q_MAX (COIN_Q_MAX)
         ) u_coin (
            .CLK_12M (CLK_12M),
            .RESET   (RESET),
            .tick    (tick_q),
            .btn_n   (btn_q[gi][B_COIN]),
            .pulse   (coin[gi]),
            .q       (qn[gi])
         );
      end
   endgenerate

   always_comb begin
      sys_d            = '0;
      sys_d[S_SERVICE] = ~btn_q[0][B_SVC];
      sys_d[S_TEST]    = ~btn_q[1][B_SVC];
      sys_d[S_START1]  = ~btn_q[0][B_START];
      sys_d[S_START2]  = ~btn_q[1][B_START];
      sys_d[S_COIN]    = |coin;
   end

   assign unused_btn = &{btn_q[0][10], btn_q[0][7:5], btn_q[1][10], btn_q[1][7:5]};

   assign IN_P1     = ply_q[0];
   assign IN_P2     = ply_q[1];
   assign IN_SYS    = sys_q;
   assign COIN_PEND = {qn[1], qn[0]};

endmodule

// File: tb/tb_coin_input_ctrl.sv
// Bench for coin_input_ctrl: table-driven level vectors through a latency
// scoreboard, plus hand-written coin pulse sequences.
`timescale 1ns/1ps
module tb_coin_input_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] btn_p1, btn_p2;
   logic [7:0]  in_p1, in_p2, in_sys;
   logic [5:0]  coin_pend;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   coin_input_ctrl #(
      .CLK_HZ     (1000),
      .TICK_HZ    (100),
      .COIN_ON_T  (3),
      .COIN_OFF_T (3),
      .COIN_Q_MAX (7)
   ) dut (
      .CLK_12M   (clk),
      .RESET     (rst),
      .BTN_P1    (btn_p1),
      .BTN_P2    (btn_p2),
      .IN_P1     (in_p1),
      .IN_P2     (in_p2),
      .IN_SYS    (in_sys),
      .COIN_PEND (coin_pend)
   );

   typedef struct {
      logic [11:0] p1;
      logic [11:0] p2;
      logic [7:0]  e1;
      logic [7:0]  e2;
      logic [6:0]  es;
      string       name;
   } vec_t;

   typedef struct {
      int          due;
      logic [22:0] exp;
      int          idx;
   } sb_t;

   vec_t vecs[16];
   sb_t  sbq[$];

   // Coin pulse monitor on IN_SYS[7]
   logic mon_clr = 1'b0;
   logic prev_coin;
   int pulse_cnt, hi_run, lo_run, min_hi, max_hi, min_gap, q1_peak, q2_peak;

   always @(negedge clk) begin
      if (mon_clr) begin
         pulse_cnt = 0; hi_run = 0; lo_run = 0;
         min_hi = 9999; max_hi = 0; min_gap = 9999;
         q1_peak = 0; q2_peak = 0; prev_coin = 1'b0;
      end else begin
         if (in_sys[7]) begin
            if (!prev_coin) begin
               if (pulse_cnt > 0 && lo_run < min_gap) min_gap = lo_run;
               pulse_cnt++;
               lo_run = 0;
            end
            hi_run++;
         end else begin
            if (prev_coin) begin
               if (hi_run < min_hi) min_hi = hi_run;
               if (hi_run > max_hi) max_hi = hi_run;
               hi_run = 0;
            end
            lo_run++;
         end
         if (int'(coin_pend[2:0]) > q1_peak) q1_peak = int'(coin_pend[2:0]);
         if (int'(coin_pend[5:3]) > q2_peak) q2_peak = int'(coin_pend[5:3]);
         prev_coin = in_sys[7];
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end else begin
         $display("[TB] pass %s = 0x%0h", nm, act);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end else begin
         $display("[TB] pass %s = %0d", nm, act);
      end
   endtask

   task automatic sb_check();
      sb_t e;
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
         e = sbq.pop_front();
         chk(vecs[e.idx].name, int'({in_p1, in_p2, in_sys[6:0]}), int'(e.exp));
      end
   endtask

   task automatic mon_reset();
      @(posedge clk);
      mon_clr = 1'b1;
      @(posedge clk);
      mon_clr = 1'b0;
   endtask

   task automatic coin_press(input bit c1, input bit c2, input int lo, input int hi);
      @(negedge clk);
      btn_p1 = c1 ? 12'hDFF : 12'hFFF;
      btn_p2 = c2 ? 12'hDFF : 12'hFFF;
      repeat (lo) @(negedge clk);
      btn_p1 = 12'hFFF;
      btn_p2 = 12'hFFF;
      repeat (hi - 1) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{12'hFFF,  12'hFFF,  8'h00, 8'h00, 7'h00, "idle"};
      vecs[1]  = '{~12'h001, 12'hFFF,  8'h04, 8'h00, 7'h00, "p1_up"};
      vecs[2]  = '{~12'h003, 12'hFFF,  8'h00, 8'h00, 7'h00, "p1_up_down"};
      vecs[3]  = '{~12'h004, 12'hFFF,  8'h02, 8'h00, 7'h00, "p1_left"};
      vecs[4]  = '{~12'h00C, 12'hFFF,  8'h00, 8'h00, 7'h00, "p1_left_right"};
      vecs[5]  = '{~12'h008, 12'hFFF,  8'h01, 8'h00, 7'h00, "p1_right"};
      vecs[6]  = '{~12'h002, 12'hFFF,  8'h08, 8'h00, 7'h00, "p1_down"};
      vecs[7]  = '{~12'h010, 12'hFFF,  8'h10, 8'h00, 7'h00, "p1_fire"};
      vecs[8]  = '{~12'h005, 12'hFFF,  8'h06, 8'h00, 7'h00, "p1_up_left"};
      vecs[9]  = '{12'hFFF,  ~12'h007, 8'h00, 8'h02, 7'h00, "p2_ud_left"};
      vecs[10] = '{12'hFFF,  ~12'h01A, 8'h00, 8'h19, 7'h00, "p2_dn_rt_fire"};
      vecs[11] = '{~12'h100, 12'hFFF,  8'h00, 8'h00, 7'h04, "p1_start"};
      vecs[12] = '{12'hFFF,  ~12'h100, 8'h00, 8'h00, 7'h08, "p2_start"};
      vecs[13] = '{~12'h800, 12'hFFF,  8'h00, 8'h00, 7'h01, "p1_service"};
      vecs[14] = '{12'hFFF,  ~12'h800, 8'h00, 8'h00, 7'h02, "p2_test"};
      vecs[15] = '{~12'h01F, ~12'h91F, 8'h10, 8'h10, 7'h0A, "all_pressed"};

      rst    = 1'b1;
      btn_p1 = 12'hFFF;
      btn_p2 = 12'hFFF;
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({in_p1, in_p2, in_sys}), 0);
      chk("reset_pend", int'(coin_pend), 0);
      rst = 1'b0;

      // Level vectors, one per clock, checked two clocks later
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         sb_check();
         btn_p1 = vecs[i].p1;
         btn_p2 = vecs[i].p2;
         sbq.push_back('{cyc + 2, {vecs[i].e1, vecs[i].e2, vecs[i].es}, i});
      end
      @(negedge clk);
      btn_p1 = 12'hFFF;
      btn_p2 = 12'hFFF;
      sb_check();
      repeat (4) begin
         @(negedge clk);
         sb_check();
      end
      chk("sb_drained", sbq.size(), 0);
      chk("no_coin_from_levels", int'(coin_pend), 0);

      // Single held press
      mon_reset();
      coin_press(1'b1, 1'b0, 100, 60);
      chk("single_pulses", pulse_cnt, 1);
      chk_rng("single_min_hi", min_hi, 20, 30);
      chk_rng("single_max_hi", max_hi, 20, 30);
      chk("single_q1_peak", q1_peak, 1);
      chk("single_pend_end", int'(coin_pend), 0);
      chk("single_low_end", hi_run, 0);

      // Three presses 5 clk apart
      mon_reset();
      for (int i = 0; i < 3; i++) coin_press(1'b1, 1'b0, 2, 3);
      repeat (260) @(negedge clk);
      chk("three_pulses", pulse_cnt, 3);
      chk_rng("three_min_gap", min_gap, 20, 9999);
      chk_rng("three_min_hi", min_hi, 20, 30);
      chk_rng("three_max_hi", max_hi, 20, 30);
      chk_rng("three_q1_peak", q1_peak, 2, 3);
      chk("three_pend_end", int'(coin_pend), 0);

      // Ten rapid presses saturate the queue
      mon_reset();
      for (int i = 0; i < 10; i++) coin_press(1'b1, 1'b0, 1, 1);
      repeat (600) @(negedge clk);
      chk("sat_q1_peak", q1_peak, 7);
      chk_rng("sat_pulses", pulse_cnt, 7, 8);
      chk_rng("sat_min_gap", min_gap, 20, 9999);
      chk("sat_pend_end", int'(coin_pend), 0);

      // Both players on the same clock
      mon_reset();
      coin_press(1'b1, 1'b1, 2, 80);
      chk("both_pulses", pulse_cnt, 1);
      chk_rng("both_hi", max_hi, 20, 30);
      chk("both_q1_peak", q1_peak, 1);
      chk("both_q2_peak", q2_peak, 1);
      chk("both_pend_end", int'(coin_pend), 0);

      // Reset in the middle of a pulse with three coins still queued
      mon_reset();
      for (int i = 0; i < 4; i++) coin_press(1'b1, 1'b0, 1, 1);
      repeat (12) @(negedge clk);
      chk("midon_coin_high", int'(in_sys[7]), 1);
      chk("midon_pend", int'(coin_pend), 3);
      rst = 1'b1;
      @(negedge clk);
      chk("midon_reset_sys", int'(in_sys), 0);
      chk("midon_reset_pend", int'(coin_pend), 0);
      rst = 1'b0;
      mon_reset();
      repeat (100) @(negedge clk);
      chk("post_reset_pulses", pulse_cnt, 0);
      chk("post_reset_pend", int'(coin_pend), 0);

      // New press after reset still works
      mon_reset();
      coin_press(1'b1, 1'b0, 2, 70);
      chk("post_reset_new_press", pulse_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
